branch_hazard_ctrl: RTL and testbench
=====================================

# branch_hazard_ctrl

Decode-stage controller for the branch comparator. It tracks in-flight register writers in the E, M and W stages and stalls a branch in D until its operands are available. It drives the forwarding selects for the comparator's two inputs, passes the compare opcode through, and turns the comparator result into a one-cycle redirect. It sits between the decoder, the D/E pipeline register enable and the comparator's operand muxes.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `d_valid` in 1: D holds a real instruction.
- `d_is_branch` in 1: D instruction is a beq/bne.
- `d_cmp_op` in 2: compare opcode; `CMP_BEQ` or `CMP_BNE`.
- `d_rs`, `d_rt` in 5 each: branch source registers.
- `d_wr_en` in 1: D instruction writes a register.
- `d_wr_addr` in 5: destination; 0 means no write.
- `d_wr_class` in 2: `WC_NONE`=0, `WC_ALU`=1 (result at end of E), `WC_LOAD`=2 (result at end of M).
- `cmp_out` in 1: comparator result for the current cycle.
- `stall` out 1: freeze PC and the F/D register; insert a bubble into E.
- `fwd_rs_sel`, `fwd_rt_sel` out 2 each: `FWD_RF`=0, `FWD_M`=1, `FWD_W`=2.
- `cmp_op_out` out 2: drives the comparator opcode.
- `br_resolve` out 1: a branch resolves this cycle.
- `br_taken` out 1: redirect the PC to the branch target.
- `stall_cnt` out `CNT_W`: count of branch stall cycles.

## Operation
- Three slot registers: E, M, W. Each holds `{valid, addr[4:0], class[1:0]}`. A slot counts as a writer only when `valid` is set and `addr` is not 0.
- Slot advance, every cycle:
  - W takes M, and M takes E.
  - E takes the D instruction when `!stall && d_valid && d_wr_en && d_wr_addr!=0`; otherwise E takes a bubble (valid=0).
- Per-operand check, for `r` = rs and then rt; operand 0 never stalls and always uses `FWD_RF`:
  - E slot matches `r` with class ALU or LOAD: hazard.
  - Otherwise, M slot matches with class LOAD: hazard.
  - Otherwise, M slot matches with class ALU: sel = `FWD_M`.
  - Otherwise, W slot matches: sel = `FWD_W`.
  - Otherwise: sel = `FWD_RF`.
  - The youngest matching slot decides the result. M beats W, and E beats both.
- `stall = d_valid && d_is_branch && (hazard_rs || hazard_rt)`. Non-branch instructions never stall here.
- `br_resolve = d_valid && d_is_branch && !stall`.
- `br_taken = br_resolve && cmp_out`.
- `cmp_op_out = d_cmp_op`.
- `stall_cnt` increments on every cycle with `stall=1` and saturates at all-ones.
- An opcode outside BEQ/BNE is treated as never-taken: `br_taken=0`, and `br_resolve` still asserts.

## Timing
- `stall`, the fwd selects, `br_resolve`, `br_taken` and `cmp_op_out` are combinational from the D inputs and the slot registers. There is no register on these paths.
- Reset values: all slots invalid and `stall_cnt=0`. This gives `stall=0`, both selects `FWD_RF`, `br_resolve=0` and `br_taken=0`.
- Reset asserted mid-stall clears the slots on that edge. The stall drops the next cycle if D is unchanged.
- Stall latency:
  - ALU producer immediately ahead (in E): 1 stall, then `FWD_M`.
  - Load immediately ahead: 2 stalls, then `FWD_W`.
  - Load two ahead (in M): 1 stall, then `FWD_W`.
  - Maximum is 2 consecutive stall cycles.
- A stalled branch is re-evaluated every cycle with the same D inputs. It resolves exactly once, in its first non-stall cycle.
- rs == rt with a hazard gives a single stall stream, with no double count.

## Structure
- The shared macro/package holds:
  - `CMP_BEQ` and `CMP_BNE` (already defined with the comparator).
  - `FWD_RF`, `FWD_M` and `FWD_W`.
  - `WC_NONE`, `WC_ALU` and `WC_LOAD`.
  - The slot field widths.
- Sub-module `br_fwd_sel` is instantiated twice, once for rs and once for rt. It takes a register number and the three slots, and returns `{hazard, sel[1:0]}`.
- The top level holds the slot registers, the stall/resolve logic and the counter.

## Test plan
- ALU writer then dependent branch: `addu $8` then `beq $8,$9`.
  - `stall=1` for 1 cycle, then `fwd_rs_sel=FWD_M`, `br_resolve=1`, `stall_cnt=1`.
- Load writer then dependent branch: `lw $8` then `bne $0,$8`.
  - 2 stall cycles, then `fwd_rt_sel=FWD_W`. `$0` operand stays `FWD_RF`. `stall_cnt=2`.
- Independent writer then branch: `addu $8` then `beq $9,$10`.
  - Zero stalls, both selects `FWD_RF`, `br_resolve` on the first cycle.
  - With `cmp_out=1`: `br_taken=1`.
- Same register in two slots: M=ALU `$8` and W=LOAD `$8`, then `beq $8,$8`.
  - No stall; both selects `FWD_M`, because the youngest slot wins.
- Reset in the second load-use stall cycle: `reset=1` for one edge, then D held.
  - Next cycle `stall=0`, `br_resolve=1`, and `stall_cnt` restarts from 0.
- Counter saturation: with `CNT_W=4`, run 20 ALU-hazard branches.
  - `stall_cnt` holds at 15.

Source files
------------

// File: rtl/branch_hazard_ctrl_pkg.sv
// branch_hazard_ctrl_pkg
//   Shared encodings for the decode-stage branch hazard controller:
//   comparator opcodes, forwarding selects, writer classes, the layout of
//   one pipeline writer slot, and the slot-match helper.
package branch_hazard_ctrl_pkg;

  // Comparator opcodes
  localparam logic [1:0] CMP_BEQ = 2'd0;
  localparam logic [1:0] CMP_BNE = 2'd1;

  // Forwarding selects for the comparator operand muxes
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  // Writer class: when the producer's result becomes available
  localparam logic [1:0] WC_NONE = 2'd0;
  localparam logic [1:0] WC_ALU  = 2'd1;  // end of E
  localparam logic [1:0] WC_LOAD = 2'd2;  // end of M

  // Slot field widths
  localparam int unsigned REG_W   = 5;
  localparam int unsigned CLASS_W = 2;

  typedef struct packed {
    logic               valid;
    logic [REG_W-1:0]   addr;
    logic [CLASS_W-1:0] cls;
  } slot_t;

  // A slot produces register r only if it is a real writer of a non-zero register.
  function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid && (s.addr != 5'd0) && (s.addr == r);
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_br_fwd_sel.sv
// br_fwd_sel
//   Per-operand hazard / forwarding decision for one branch source register.
//   Ports:
//     r_i        in  5 : source register number
//     e_slot_i   in    : writer slot currently in E
//     m_slot_i   in    : writer slot currently in M
//     w_slot_i   in    : writer slot currently in W
//     hazard_o   out 1 : operand not yet available, branch must wait
//     sel_o      out 2 : forwarding select (FWD_RF / FWD_M / FWD_W)
module br_fwd_sel
  import branch_hazard_ctrl_pkg::*;
(
  input  logic [4:0] r_i,
  input  slot_t      e_slot_i,
  input  slot_t      m_slot_i,
  input  slot_t      w_slot_i,
  output logic       hazard_o,
  output logic [1:0] sel_o
);

  // Priority chain from youngest (E) to oldest (W); first match decides.
  always_comb begin
    hazard_o = 1'b0;
    sel_o    = FWD_RF;
    if (r_i == 5'd0) begin
      // $0 is hard-wired, never depends on a producer
      hazard_o = 1'b0;
      sel_o    = FWD_RF;
    end else if (slot_match(e_slot_i, r_i) &&
                 ((e_slot_i.cls == WC_ALU) || (e_slot_i.cls == WC_LOAD))) begin
      // Result not produced until end of E at the earliest
      hazard_o = 1'b1;
    end else if (slot_match(m_slot_i, r_i) && (m_slot_i.cls == WC_LOAD)) begin
      // Load data only exists at end of M
      hazard_o = 1'b1;
    end else if (slot_match(m_slot_i, r_i) && (m_slot_i.cls == WC_ALU)) begin
      sel_o = FWD_M;
    end else if (slot_match(w_slot_i, r_i)) begin
      sel_o = FWD_W;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
//   Decode-stage controller for the branch comparator. Tracks register
//   writers in E/M/W, stalls a branch in D until its operands can be
//   forwarded, drives the comparator forwarding selects and opcode, and
//   produces a one-cycle resolve/taken pulse.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     d_valid, d_is_branch       : D instruction qualifiers
//     d_cmp_op                   : compare opcode (CMP_BEQ / CMP_BNE)
//     d_rs, d_rt                 : branch source registers
//     d_wr_en, d_wr_addr,
//     d_wr_class                 : D instruction's register write
//     cmp_out                    : comparator result this cycle
//     stall                      : freeze PC and F/D, bubble into E
//     fwd_rs_sel, fwd_rt_sel     : comparator operand forwarding selects
//     cmp_op_out                 : comparator opcode
//     br_resolve, br_taken       : branch resolves / redirects this cycle
//     stall_cnt                  : saturating count of branch stall cycles
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic             d_is_branch,
  input  logic [1:0]       d_cmp_op,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_wr_en,
  input  logic [4:0]       d_wr_addr,
  input  logic [1:0]       d_wr_class,
  input  logic             cmp_out,
  output logic             stall,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic [1:0]       cmp_op_out,
  output logic             br_resolve,
  output logic             br_taken,
  output logic [CNT_W-1:0] stall_cnt
);

  slot_t            e_q, m_q, w_q;
  slot_t            e_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard_rs_s, hazard_rt_s;
  logic             op_known_s;

  br_fwd_sel u_fwd_rs (
    .r_i      (d_rs),
    .e_slot_i (e_q),
    .m_slot_i (m_q),
    .w_slot_i (w_q),
    .hazard_o (hazard_rs_s),
    .sel_o    (fwd_rs_sel)
  );

  br_fwd_sel u_fwd_rt (
    .r_i      (d_rt),
    .e_slot_i (e_q),
    .m_slot_i (m_q),
    .w_slot_i (w_q),
    .hazard_o (hazard_rt_s),
    .sel_o    (fwd_rt_sel)
  );

  // Stall / resolve / redirect decisions, combinational from D and the slots.
  always_comb begin
    op_known_s = (d_cmp_op == CMP_BEQ) || (d_cmp_op == CMP_BNE);
    stall      = d_valid && d_is_branch && (hazard_rs_s || hazard_rt_s);
    br_resolve = d_valid && d_is_branch && !stall;
    // Unknown opcodes resolve but never redirect
    br_taken   = br_resolve && cmp_out && op_known_s;
    cmp_op_out = d_cmp_op;
    stall_cnt  = cnt_q;
  end

  // Next E slot: D writer enters only when it actually advances, else a bubble.
  always_comb begin
    e_d = '0;
    if (!stall && d_valid && d_wr_en && (d_wr_addr != 5'd0)) begin
      e_d.valid = 1'b1;
      e_d.addr  = d_wr_addr;
      e_d.cls   = d_wr_class;
    end else begin
      e_d = '0;
    end
  end

  // Saturating stall counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Slot pipeline and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= e_q;
      w_q   <= m_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;
  import branch_hazard_ctrl_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             d_valid, d_is_branch, d_wr_en, cmp_out;
  logic [1:0]       d_cmp_op, d_wr_class;
  logic [4:0]       d_rs, d_rt, d_wr_addr;
  logic             stall, br_resolve, br_taken;
  logic [1:0]       fwd_rs_sel, fwd_rt_sel, cmp_op_out;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .d_valid     (d_valid),
    .d_is_branch (d_is_branch),
    .d_cmp_op    (d_cmp_op),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_wr_en     (d_wr_en),
    .d_wr_addr   (d_wr_addr),
    .d_wr_class  (d_wr_class),
    .cmp_out     (cmp_out),
    .stall       (stall),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel),
    .cmp_op_out  (cmp_op_out),
    .br_resolve  (br_resolve),
    .br_taken    (br_taken),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    d_valid = 1'b0; d_is_branch = 1'b0; d_cmp_op = CMP_BEQ;
    d_rs = 5'd0; d_rt = 5'd0; d_wr_en = 1'b0; d_wr_addr = 5'd0;
    d_wr_class = WC_NONE; cmp_out = 1'b0;
    #1;
  endtask

  task automatic drive_writer(input logic [4:0] addr, input logic [1:0] cls);
    d_valid = 1'b1; d_is_branch = 1'b0; d_cmp_op = CMP_BEQ;
    d_rs = 5'd0; d_rt = 5'd0; d_wr_en = 1'b1; d_wr_addr = addr;
    d_wr_class = cls; cmp_out = 1'b0;
    #1;
  endtask

  task automatic drive_branch(input logic [1:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic c);
    d_valid = 1'b1; d_is_branch = 1'b1; d_cmp_op = op;
    d_rs = rs; d_rt = rt; d_wr_en = 1'b0; d_wr_addr = 5'd0;
    d_wr_class = WC_NONE; cmp_out = c;
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall); end
    checks++; if (fwd_rs_sel !== FWD_RF || fwd_rt_sel !== FWD_RF) begin failures++; $display("FAIL reset_sel got=%0d/%0d exp=0/0", fwd_rs_sel, fwd_rt_sel); end
    checks++; if (br_resolve !== 1'b0 || br_taken !== 1'b0) begin failures++; $display("FAIL reset_resolve got=%0d/%0d exp=0/0", br_resolve, br_taken); end
    checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_alu_hazard();
    do_reset();
    drive_writer(5'd8, WC_ALU);              // addu $8
    tick();
    drive_branch(CMP_BEQ, 5'd8, 5'd9, 1'b1); // beq $8,$9
    checks++; if (stall !== 1'b1 || br_resolve !== 1'b0 || br_taken !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0d/%0d/%0d exp=1/0/0", stall, br_resolve, br_taken); end
    tick();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall_drop got=%0d exp=0", stall); end
    checks++; if (fwd_rs_sel !== FWD_M || fwd_rt_sel !== FWD_RF) begin failures++; $display("FAIL alu_sel got=%0d/%0d exp=1/0", fwd_rs_sel, fwd_rt_sel); end
    checks++; if (br_resolve !== 1'b1 || br_taken !== 1'b1) begin failures++; $display("FAIL alu_resolve got=%0d/%0d exp=1/1", br_resolve, br_taken); end
    checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL alu_cnt got=%0d exp=1", stall_cnt); end
    drive_idle();
    tick();
  endtask

  task automatic test_load_hazard();
    do_reset();
    drive_writer(5'd8, WC_LOAD);             // lw $8
    tick();
    drive_branch(CMP_BNE, 5'd0, 5'd8, 1'b0); // bne $0,$8
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL load_stall1 got=%0d exp=1", stall); end
    tick();
    checks++; if (stall !== 1'b1 || stall_cnt !== 4'd1) begin failures++; $display("FAIL load_stall2 got=%0d cnt=%0d exp=1 cnt=1", stall, stall_cnt); end
    tick();
    checks++; if (stall !== 1'b0 || br_resolve !== 1'b1 || br_taken !== 1'b0) begin failures++; $display("FAIL load_resolve got=%0d/%0d/%0d exp=0/1/0", stall, br_resolve, br_taken); end
    checks++; if (fwd_rt_sel !== FWD_W || fwd_rs_sel !== FWD_RF) begin failures++; $display("FAIL load_sel got=%0d/%0d exp=0/2", fwd_rs_sel, fwd_rt_sel); end
    checks++; if (stall_cnt !== 4'd2 || cmp_op_out !== CMP_BNE) begin failures++; $display("FAIL load_cnt_op got=%0d/%0d exp=2/1", stall_cnt, cmp_op_out); end
    drive_idle();
    tick();
  endtask

  task automatic test_independent();
    do_reset();
    drive_writer(5'd8, WC_ALU);
    tick();
    drive_branch(CMP_BEQ, 5'd9, 5'd10, 1'b1);
    checks++; if (stall !== 1'b0 || br_resolve !== 1'b1 || br_taken !== 1'b1) begin failures++; $display("FAIL indep_taken got=%0d/%0d/%0d exp=0/1/1", stall, br_resolve, br_taken); end
    checks++; if (fwd_rs_sel !== FWD_RF || fwd_rt_sel !== FWD_RF) begin failures++; $display("FAIL indep_sel got=%0d/%0d exp=0/0", fwd_rs_sel, fwd_rt_sel); end
    cmp_out = 1'b0;
    #1;
    checks++; if (br_taken !== 1'b0 || br_resolve !== 1'b1) begin failures++; $display("FAIL indep_not_taken got=%0d/%0d exp=1/0", br_resolve, br_taken); end
    checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL indep_cnt got=%0d exp=0", stall_cnt); end
    drive_idle();
    tick();
  endtask

  task automatic test_youngest_wins();
    do_reset();
    drive_writer(5'd8, WC_LOAD);  // lw $8
    tick();
    drive_writer(5'd8, WC_ALU);   // addu $8
    tick();
    // Non-branch reading $8 while an ALU writer of $8 is in E: never stalls
    drive_idle();
    d_valid = 1'b1; d_rs = 5'd8;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nonbranch_stall got=%0d exp=0", stall); end
    tick();
    drive_branch(CMP_BEQ, 5'd8, 5'd8, 1'b0); // M=ALU $8, W=LOAD $8
    checks++; if (stall !== 1'b0 || br_resolve !== 1'b1) begin failures++; $display("FAIL young_stall got=%0d/%0d exp=0/1", stall, br_resolve); end
    checks++; if (fwd_rs_sel !== FWD_M || fwd_rt_sel !== FWD_M) begin failures++; $display("FAIL young_sel got=%0d/%0d exp=1/1", fwd_rs_sel, fwd_rt_sel); end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive_writer(5'd8, WC_LOAD);
    tick();
    drive_branch(CMP_BNE, 5'd0, 5'd8, 1'b1);
    tick();
    checks++; if (stall !== 1'b1 || stall_cnt !== 4'd1) begin failures++; $display("FAIL rst_mid_pre got=%0d cnt=%0d exp=1 cnt=1", stall, stall_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || br_resolve !== 1'b1 || br_taken !== 1'b1) begin failures++; $display("FAIL rst_mid_resolve got=%0d/%0d/%0d exp=0/1/1", stall, br_resolve, br_taken); end
    checks++; if (stall_cnt !== 4'd0 || fwd_rt_sel !== FWD_RF) begin failures++; $display("FAIL rst_mid_cnt got=%0d sel=%0d exp=0 sel=0", stall_cnt, fwd_rt_sel); end
    drive_idle();
    tick();
  endtask

  task automatic test_bad_opcode();
    do_reset();
    drive_branch(2'd3, 5'd4, 5'd5, 1'b1);
    checks++; if (br_resolve !== 1'b1 || br_taken !== 1'b0 || cmp_op_out !== 2'd3) begin failures++; $display("FAIL bad_op got=%0d/%0d/%0d exp=1/0/3", br_resolve, br_taken, cmp_op_out); end
    drive_idle();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive_writer(5'd8, WC_ALU);
      tick();
      drive_branch(CMP_BEQ, 5'd8, 5'd9, 1'b0);
      tick();  // stall cycle counted at this edge
      tick();  // resolve cycle
      if (i == 13) begin
        checks++; if (stall_cnt !== 4'd14) begin failures++; $display("FAIL sat_mid got=%0d exp=14", stall_cnt); end
      end
    end
    checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt); end
    drive_idle();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_alu_hazard();
    test_load_hazard();
    test_independent();
    test_youngest_wins();
    test_reset_mid_stall();
    test_bad_opcode();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
